// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts the one-cycle-latency read port of an upstream
// fifo_sync into a valid/ready stream through a 2-entry in-order skid buffer.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the 16-bit xfer_cnt
// output counting accepted beats (wraps 0xFFFF -> 0x0000).
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned LVL_W = 3;

    // Skid buffer state: ent0 is always the oldest entry.
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_nxt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;
    logic [DATA_WIDTH-1:0] ent0_nxt;
    logic [DATA_WIDTH-1:0] ent1_nxt;

    logic                  push_c;
    logic                  pop_c;
    logic [LVL_W-1:0]      level_c;
    logic                  rd_c;

    // Read issue: only when the word it fetches is guaranteed a free slot.
    always_comb begin
        push_c  = inflight;
        pop_c   = (occ != '0) && m_ready;
        level_c = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop_c);
        rd_c    = en && !fifo_empty && rst_n && (level_c < LVL_W'(2));
    end

    assign fifo_rd_en = rd_c;
    assign fifo_cs    = rd_c;
    assign m_valid    = (occ != '0);
    assign m_data     = ent0;

    // Next buffer contents for the push/pop combination of this cycle.
    always_comb begin
        occ_nxt  = occ;
        ent0_nxt = ent0;
        ent1_nxt = ent1;
        case ({push_c, pop_c})
            2'b10: begin
                if (occ == '0) begin
                    ent0_nxt = fifo_data;
                end else begin
                    ent1_nxt = fifo_data;
                end
                occ_nxt = occ + OCC_W'(1);
            end
            2'b01: begin
                ent0_nxt = ent1;
                occ_nxt  = occ - OCC_W'(1);
            end
            2'b11: begin
                // Occupancy unchanged; the new word joins behind the survivor.
                if (occ == OCC_W'(1)) begin
                    ent0_nxt = fifo_data;
                end else begin
                    ent0_nxt = ent1;
                    ent1_nxt = fifo_data;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous reset that drops all words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= rd_c;
            ent0     <= ent0_nxt;
            ent1     <= ent1_nxt;
        end
    end

    // A push into a full buffer without a pop would lose data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_c && !pop_c && (occ == OCC_W'(2))));

`ifdef FIFO_RD_STREAM_CNT_EN
    localparam int unsigned CNT_W = 16;

    // Accepted-beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (pop_c) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of the data path in bits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have input en, 1 bit; when high, the block may issue new FIFO reads.
REQ-005 The block SHALL have input fifo_empty, 1 bit, the empty flag of the upstream fifo_sync.
REQ-006 The block SHALL have input fifo_data, DATA_WIDTH bits, the registered data_out of the upstream fifo_sync.
REQ-007 The block SHALL have output fifo_cs, 1 bit, the chip select to the upstream fifo_sync.
REQ-008 The block SHALL have output fifo_rd_en, 1 bit, the read enable to the upstream fifo_sync.
REQ-009 The block SHALL have output m_valid, 1 bit, meaning the downstream beat is valid.
REQ-010 The block SHALL have input m_ready, 1 bit, meaning downstream accepts the beat.
REQ-011 The block SHALL have output m_data, DATA_WIDTH bits, the downstream beat payload.

Function
REQ-012 The upstream read latency SHALL be one cycle: fifo_rd_en high in cycle T means fifo_data is valid in cycle T+1.
REQ-013 The block SHALL hold a 1-bit inflight register equal to fifo_rd_en of the previous cycle.
REQ-014 The block SHALL hold a 2-entry in-order skid buffer with occupancy occ in the range 0..2.
REQ-015 fifo_rd_en SHALL be the combinational result en && !fifo_empty && !rst_n_low && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
REQ-016 fifo_cs SHALL equal fifo_rd_en.
REQ-017 When inflight=1, fifo_data SHALL be written into the buffer at the end of that cycle (push).
REQ-018 m_valid SHALL equal (occ != 0), and m_data SHALL be the oldest entry.
REQ-019 The beat presented on m_data SHALL be the oldest entry: m_valid high in cycle T+2 after rd_en in cycle T with an empty buffer.
REQ-020 On a simultaneous push and pop, occ SHALL be unchanged and order SHALL be preserved.
REQ-021 While m_valid && !m_ready, m_data and m_valid SHALL remain stable.
REQ-022 The block SHALL never push when occ=2 without a pop; this is guaranteed by REQ-015, and overflow is a design error.
REQ-023 When en goes low, no new reads SHALL be issued; the in-flight word is still captured and buffered beats are still delivered.
REQ-024 With en=1, FIFO non-empty and m_ready held high, the block SHALL sustain one beat per cycle.
REQ-025 A fifo_empty assertion SHALL stop reads in the same cycle; reads SHALL NOT be issued speculatively.

Reset
REQ-026 rst_n=0 at a clock edge SHALL clear occ, inflight and the buffer, giving m_valid=0, m_data=0 and fifo_rd_en=fifo_cs=0 for the cycle.
REQ-027 A reset mid-operation SHALL discard any in-flight and buffered words without emitting them.
REQ-028 The first read after reset SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-029 The macro FIFO_RD_STREAM_CNT_EN, when defined, SHALL add output xfer_cnt [15:0], counting accepted beats (m_valid && m_ready), reset to 0 and wrapping 0xFFFF to 0x0000.
REQ-030 When FIFO_RD_STREAM_CNT_EN is undefined, xfer_cnt and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Scenario: reset, then FIFO holds 1, 10, 100 with m_ready=1 and en=1 -> m_data is 1, 10, 100 on consecutive cycles, with the first valid two cycles after the first rd_en.
REQ-032 Scenario: stream 2**i for i=0..7 with m_ready=0 -> exactly two reads are issued, occ=2, rd_en stays low and m_data=1 is stable; raising m_ready drains all 8 beats in order.
REQ-033 Scenario: m_ready toggles 1,0,1,0 during an 8-word burst -> no loss and no duplication, all 8 values received in order.
REQ-034 Scenario: the FIFO goes empty after 3 words (7, 8, 9) -> rd_en drops the same cycle and exactly 3 beats are emitted.
REQ-035 Scenario: rst_n=0 asserted while occ=2 and inflight=1 -> the next cycle shows m_valid=0 and rd_en=0, and the old words never appear.
REQ-036 Scenario (with FIFO_RD_STREAM_CNT_EN): 65537 accepted beats -> xfer_cnt=1.
